// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: latches operands, drives a one-hot select for
// the operation's settle time, then captures the (possibly double-width) result.
module alu_op_sequencer #(
   parameter int BITS      = 32,
   parameter int SIG_COUNT = 12,
   parameter int MUL_LAT   = 4,
   parameter int DIV_LAT   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           opcode,
   input  logic [BITS-1:0]      a,
   input  logic [BITS-1:0]      b,
   input  logic [2*BITS-1:0]    alu_result,
   output logic [SIG_COUNT-1:0] ctrl_signal,
   output logic [BITS-1:0]      alu_x,
   output logic [BITS-1:0]      alu_y,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [BITS-1:0]      z_hi,
   output logic [BITS-1:0]      z_lo
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EXEC = 1'b1;

   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_LAST = 4'd11;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
   localparam logic [SIG_COUNT-1:0] SEL_ONE = {{(SIG_COUNT-1){1'b0}}, 1'b1};

   logic [0:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic [SIG_COUNT-1:0] ctrl_q,  ctrl_d;
   logic [BITS-1:0]      x_q,     x_d;
   logic [BITS-1:0]      y_q,     y_d;
   logic                 wide_q,  wide_d;
   logic [BITS-1:0]      zhi_q,   zhi_d;
   logic [BITS-1:0]      zlo_q,   zlo_d;
   logic                 done_q,  done_d;
   logic                 err_q,   err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      x_d     = x_q;
      y_d     = y_q;
      wide_d  = wide_q;
      zhi_d   = zhi_q;
      zlo_d   = zlo_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (opcode <= OP_LAST) begin
                  x_d     = a;
                  y_d     = b;
                  ctrl_d  = SEL_ONE << opcode;
                  wide_d  = (opcode == OP_MUL) || (opcode == OP_DIV);
                  state_d = S_EXEC;
                  if (opcode == OP_MUL)      cnt_d = MUL_CNT;
                  else if (opcode == OP_DIV) cnt_d = DIV_CNT;
                  else                       cnt_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Only multiply and divide produce a meaningful upper half.
               zhi_d   = wide_q ? alu_result[2*BITS-1:BITS] : '0;
               zlo_d   = alu_result[BITS-1:0];
               ctrl_d  = '0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ctrl_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         wide_q  <= 1'b0;
         zhi_q   <= '0;
         zlo_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         x_q     <= x_d;
         y_q     <= y_d;
         wide_q  <= wide_d;
         zhi_q   <= zhi_d;
         zlo_q   <= zlo_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign ctrl_signal = ctrl_q;
   assign alu_x       = x_q;
   assign alu_y       = y_q;
   assign busy        = (state_q == S_EXEC);
   assign done        = done_q;
   assign err         = err_q;
   assign z_hi        = zhi_q;
   assign z_lo        = zlo_q;

endmodule
